// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to instruction
// memory and holds each returned word with its PC for decode. Handles PC redirects,
// squashing wrong-path work, and halts on a misaligned redirect target.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDrain,
    StHold,
    StFault
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fault_q, fault_d;
  // A misaligned redirect arrived while a stale response was still owed; halt after it.
  logic        fault_pend_q, fault_pend_d;
  logic        misaligned;

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= Nop;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fault_pend_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      fault_pend_q  <= fault_pend_d;
    end
  end

  // Next-state logic; a redirect overrides all normal progress.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    fault_pend_d  = fault_pend_q;
    misaligned    = (redirect_pc[1:0] != 2'b00);

    if (redirect_valid) begin
      instr_valid_d = 1'b0;
      if (misaligned) begin
        fault_d = 1'b1;
      end else begin
        pc_d    = redirect_pc;
        fault_d = 1'b0;
      end
      // A response is still owed to the old PC: wait it out before acting on the target.
      if ((state_q == StWait || state_q == StDrain) && !imem_rsp_valid) begin
        state_d      = StDrain;
        fault_pend_d = misaligned;
      end else begin
        state_d      = misaligned ? StFault : StReq;
        fault_pend_d = 1'b0;
      end
    end else begin
      case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (imem_req_ready) state_d = StWait;
        end
        StWait: begin
          if (imem_rsp_valid) begin
            instr_d       = imem_rsp_data;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 32'd4;
            state_d       = StHold;
          end
        end
        StHold: begin
          if (instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = StReq;
          end
        end
        StDrain: begin
          if (imem_rsp_valid) begin
            state_d      = fault_pend_q ? StFault : StReq;
            fault_pend_d = 1'b0;
          end
        end
        StFault: instr_valid_d = 1'b0;
        default: state_d = StIdle;
      endcase
    end
  end

  // Request only from REQ, never in a redirect cycle so the old PC is never accepted.
  always_comb begin
    imem_req_valid = (state_q == StReq) && !redirect_valid;
    imem_req_addr  = pc_q;
    instr          = instr_q;
    instr_pc       = instr_pc_q;
    instr_valid    = instr_valid_q;
    fetch_fault    = fault_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a memory model with configurable latency,
// a program-order PC model and directed plus randomized stimulus.
module tb_instruction_fetch;

  localparam logic [31:0] RstPc = 32'hFFFF_FFFC;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  instruction_fetch #(.RESET_PC(RstPc)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory / reference model state
  int          ready_pct = 100;
  int          lat       = 1;
  logic        mem_pend  = 1'b0;
  int          mem_cnt   = 0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] exp_pc    = RstPc;
  logic        exp_fault = 1'b0;
  int          n_acc     = 0;
  int          cyc       = 0;
  int          acc_cyc[$];
  logic [31:0] acc_addr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory inputs, sample at negedge+1, update model, advance.
  task automatic step();
    logic accept;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    imem_rsp_valid = mem_pend && (mem_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
    #1;
    chk1("no_req_on_redirect", imem_req_valid && redirect_valid, 1'b0);
    accept = imem_req_valid && imem_req_ready;
    if (accept) begin
      chk1("one_outstanding", mem_pend && !imem_rsp_valid, 1'b0);
      chk32("req_addr", imem_req_addr, exp_pc);
    end
    chk1("fetch_fault", fetch_fault, exp_fault);
    if (exp_fault) chk1("fault_quiet", imem_req_valid || instr_valid, 1'b0);
    if (instr_valid) begin
      chk32("instr_pc", instr_pc, exp_pc);
      chk32("instr_data", instr, mem_word(instr_pc));
    end
    // Program-order model: redirect wins over consume.
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        exp_fault = 1'b1;
      end else begin
        exp_pc    = redirect_pc;
        exp_fault = 1'b0;
      end
    end else if (instr_valid && instr_ready) begin
      exp_pc = exp_pc + 32'd4;
    end
    if (imem_rsp_valid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (accept) begin
      mem_pend = 1'b1;
      mem_cnt  = lat - 1;
      mem_addr = imem_req_addr;
      n_acc++;
      acc_cyc.push_back(cyc);
      acc_addr.push_back(imem_req_addr);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 50) begin
      step();
      n++;
    end
    checks++;
    assert (n < 50) else begin
      errors++;
      $error("FAIL %s: observed timeout after %0d cycles expected instr_valid", tag, n);
    end
  endtask

  task automatic wait_accept(input string tag);
    int n  = 0;
    int n0 = n_acc;
    while (n_acc == n0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    assert (n < 50) else begin
      errors++;
      $error("FAIL %s: observed timeout after %0d cycles expected request", tag, n);
    end
  endtask

  initial begin
    int n0;
    logic [31:0] p;
    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values
    #12;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk32("rst_instr", instr, Nop);
    chk32("rst_instr_pc", instr_pc, RstPc);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk1("rst_fault", fetch_fault, 1'b0);

    // IDLE cycle, then request at RESET_PC; zero-wait throughput and PC wrap
    @(negedge clk);
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk1("idle_no_req", imem_req_valid, 1'b0);
    step();
    #1;
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk32("first_req_addr", imem_req_addr, RstPc);
    acc_cyc.delete();
    acc_addr.delete();
    wait_accept("acc0");
    wait_accept("acc1");
    chk32("wrap_addr0", acc_addr[0], RstPc);
    chk32("wrap_addr1", acc_addr[1], 32'h0000_0000);
    chk32("spacing_wrap", acc_cyc[1] - acc_cyc[0], 32'd3);

    // Redirect from HOLD to 0x100: request at new PC next cycle, then 3-cycle stream
    instr_ready = 1'b0;
    wait_valid("hold0");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    #1;
    chk1("redir_req_valid", imem_req_valid, 1'b1);
    chk32("redir_req_addr", imem_req_addr, 32'h0000_0100);
    instr_ready = 1'b1;
    acc_cyc.delete();
    acc_addr.delete();
    wait_accept("acc100");
    wait_accept("acc104");
    chk32("seq_addr0", acc_addr[0], 32'h0000_0100);
    chk32("seq_addr1", acc_addr[1], 32'h0000_0104);
    chk32("spacing_seq", acc_cyc[1] - acc_cyc[0], 32'd3);

    // Decode stall for 5 cycles: no new request, output stable (checked in step)
    instr_ready = 1'b0;
    wait_valid("stall");
    p  = instr_pc;
    n0 = n_acc;
    repeat (5) step();
    chk32("stall_no_req", n_acc, n0);
    chk32("stall_pc", instr_pc, p);
    instr_ready = 1'b1;
    step();
    #1;
    chk1("release_req_valid", imem_req_valid, 1'b1);
    chk32("release_req_addr", imem_req_addr, p + 32'd4);

    // Redirect to 0x200 in WAIT with a late stale response
    lat = 3;
    wait_accept("acc_wait");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    acc_addr.delete();
    wait_accept("acc200");
    chk32("drain_addr", acc_addr[0], 32'h0000_0200);

    // Redirect coincident with response in WAIT
    lat = 1;
    wait_accept("acc_coin");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0240;
    step();
    redirect_valid = 1'b0;
    #1;
    chk1("coin_req_valid", imem_req_valid, 1'b1);
    chk32("coin_req_addr", imem_req_addr, 32'h0000_0240);

    // Redirect coincident with consume in HOLD: held instruction squashed
    instr_ready = 1'b0;
    wait_valid("hold240");
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0280;
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    wait_valid("hold280");
    chk32("squash_pc", instr_pc, 32'h0000_0280);

    // Misaligned redirect halts fetching; aligned redirect recovers
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0202;
    step();
    redirect_valid = 1'b0;
    n0 = n_acc;
    repeat (10) step();
    chk32("fault_no_req", n_acc, n0);
    chk1("fault_set", fetch_fault, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    #1;
    chk1("fault_clear", fetch_fault, 1'b0);
    chk1("recover_req_valid", imem_req_valid, 1'b1);
    chk32("recover_req_addr", imem_req_addr, 32'h0000_0300);

    // Randomized traffic against the model
    ready_pct = 70;
    for (int i = 0; i < 400; i++) begin
      lat            = $urandom_range(4, 1);
      instr_ready    = $urandom_range(1);
      redirect_valid = ($urandom_range(99) < 4);
      redirect_pc    = {$urandom_range(32'h3FFF_FFFF), 2'b00};
      step();
    end
    redirect_valid = 1'b0;

    // Asynchronous reset in WAIT with a non-NOP instruction held
    ready_pct   = 100;
    lat         = 6;
    instr_ready = 1'b1;
    wait_valid("pre_reset");
    wait_accept("acc_reset");
    #2;
    reset_n = 1'b0;
    #1;
    chk1("async_req_valid", imem_req_valid, 1'b0);
    chk32("async_instr", instr, Nop);
    chk32("async_instr_pc", instr_pc, RstPc);
    chk1("async_instr_valid", instr_valid, 1'b0);
    chk1("async_fault", fetch_fault, 1'b0);
    mem_pend  = 1'b0;
    exp_pc    = RstPc;
    exp_fault = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk1("re_idle_no_req", imem_req_valid, 1'b0);
    step();
    #1;
    chk1("re_req_valid", imem_req_valid, 1'b1);
    chk32("re_req_addr", imem_req_addr, RstPc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
